// File: rtl/bin2bcd_disp_feed_if.sv
// CPU store bus into the display feeder and the feeder's load port toward the digit-tube driver.
// Handshake: bus_we is a one-cycle store strobe with no ready (the feeder always accepts);
// digtube_ena is a one-cycle valid with no backpressure, cal_result/addr_digtube are stable while it is high.
interface bin2bcd_disp_feed_if;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        digtube_ena;
  logic [31:0] cal_result;
  logic [13:0] addr_digtube;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic [1:0]  dbg_state;

  modport master (
    output bus_we, bus_addr, bus_wdata,
    input  digtube_ena, cal_result, addr_digtube, busy, drop_cnt, dbg_state
  );

  modport slave (
    input  bus_we, bus_addr, bus_wdata,
    output digtube_ena, cal_result, addr_digtube, busy, drop_cnt, dbg_state
  );
endinterface

// File: rtl/bin2bcd_disp_feed.sv
// Memory-mapped display feeder: raw-hex passthrough or 32-step double-dabble binary-to-BCD,
// with a single-entry newest-wins pending buffer in front of the converter.
module bin2bcd_disp_feed #(
  parameter logic [31:0] ADDR_HEX = 32'hFFFF_F000,
  parameter logic [31:0] ADDR_DEC = 32'hFFFF_F004
) (
  input logic               clk,
  input logic               rst,
  bin2bcd_disp_feed_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEC_MAX = 32'd99_999_999;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_pend_valid;
  logic        r_pend_dec;
  logic [31:0] r_pend_data;
  logic [13:0] r_pend_addr;
  logic [7:0]  r_drop_cnt;

  logic [31:0] r_acc;
  logic [31:0] r_sr;
  logic [4:0]  r_cnt;
  logic [13:0] r_conv_addr;
  logic [31:0] r_result;
  logic [13:0] r_addr_out;

  logic        w_acc_hex;
  logic        w_acc_dec;
  logic        w_accept;
  logic        w_consume;
  logic        w_over;
  logic [31:0] w_adj;
  logic [31:0] w_acc_next;
  logic [31:0] w_sr_next;

  assign w_acc_hex = bus.bus_we && (bus.bus_addr == ADDR_HEX);
  assign w_acc_dec = bus.bus_we && (bus.bus_addr == ADDR_DEC);
  assign w_accept  = w_acc_hex || w_acc_dec;
  assign w_consume = (r_state == S_IDLE) && r_pend_valid;
  assign w_over    = r_pend_data > DEC_MAX;

  // A write landing on the same edge the entry is consumed refills the buffer and is not a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_dec   <= 1'b0;
      r_pend_data  <= '0;
      r_pend_addr  <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_pend_valid <= 1'b1;
        r_pend_dec   <= w_acc_dec;
        r_pend_data  <= bus.bus_wdata;
        r_pend_addr  <= bus.bus_addr[13:0];
      end else if (w_consume) begin
        r_pend_valid <= 1'b0;
      end
      if (w_accept && r_pend_valid && !w_consume && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_consume) w_state_next = (!r_pend_dec || w_over) ? S_DONE : S_CONV;
      S_CONV: if (r_cnt == 5'd31) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.digtube_ena = (r_state == S_DONE);
    bus.busy        = (r_state != S_IDLE) || r_pend_valid;
    bus.dbg_state   = r_state;
  end

  // Double-dabble step: correct nibbles >= 5 first, then shift {acc, sr} left by one.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 8; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  assign w_acc_next = {w_adj[30:0], r_sr[31]};
  assign w_sr_next  = {r_sr[30:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_conv_addr <= '0;
      r_result    <= '0;
      r_addr_out  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_consume) begin
            if (!r_pend_dec) begin
              r_result   <= r_pend_data;
              r_addr_out <= r_pend_addr;
            end else if (w_over) begin
              r_result   <= 32'hEEEE_EEEE;
              r_addr_out <= r_pend_addr;
            end else begin
              r_acc       <= '0;
              r_sr        <= r_pend_data;
              r_cnt       <= '0;
              r_conv_addr <= r_pend_addr;
            end
          end
        end
        S_CONV: begin
          r_acc <= w_acc_next;
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result   <= w_acc_next;
            r_addr_out <= r_conv_addr;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cal_result   = r_result;
  assign bus.addr_digtube = r_addr_out;
  assign bus.drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_bin2bcd_disp_feed.sv
// Scoreboarded bench for bin2bcd_disp_feed: directed corner cases plus randomized hex/dec writes
// checked against an arithmetic decimal reference.
module tb_bin2bcd_disp_feed;

  localparam logic [31:0] ADDR_HEX = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_DEC = 32'hFFFF_F004;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  bin2bcd_disp_feed_if bus_if ();

  bin2bcd_disp_feed #(.ADDR_HEX(ADDR_HEX), .ADDR_DEC(ADDR_DEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic [13:0] exp_addr_q[$];
  int          exp_cyc_q[$];

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    logic [31:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_result(input bit dec, input logic [31:0] d);
    if (!dec) return d;
    if (d > 32'd99_999_999) return 32'hEEEE_EEEE;
    return ref_bcd(d);
  endfunction

  // Monitor: every load strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus_if.digtube_ena) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ena", 64'(bus_if.cal_result), 64'hDEAD_0000_0000);
      end else begin
        check("cal_result", 64'(bus_if.cal_result), 64'(exp_q.pop_front()));
        check("addr_digtube", 64'(bus_if.addr_digtube), 64'(exp_addr_q.pop_front()));
        check("ena_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one bus cycle starting now; returns the write cycle index.
  task automatic bus_write(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           output int n);
    bus_if.bus_we    = we;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = data;
    n = cyc;
    step(1);
    bus_if.bus_we = 1'b0;
  endtask

  task automatic expect_out(input logic [31:0] res, input logic [31:0] addr, input int at_cyc);
    exp_q.push_back(res);
    exp_addr_q.push_back(addr[13:0]);
    exp_cyc_q.push_back(at_cyc);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((bus_if.busy || bus_if.digtube_ena) && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) check("idle_timeout", 64'(k), 64'(0));
  endtask

  task automatic sample_neg(output logic busy_s);
    @(negedge clk);
    busy_s = bus_if.busy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, n2;
    logic b;
    logic [31:0] d, a;
    bit dec;
    int sel;

    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = '0;
    rst = 1'b1;
    step(3);
    check("rst_cal_result", 64'(bus_if.cal_result), 64'(0));
    check("rst_addr", 64'(bus_if.addr_digtube), 64'(0));
    check("rst_ena", 64'(bus_if.digtube_ena), 64'(0));
    check("rst_busy", 64'(bus_if.busy), 64'(0));
    check("rst_drop", 64'(bus_if.drop_cnt), 64'(0));
    rst = 1'b0;
    step(2);

    // Hex write, latency 2
    bus_write(1'b1, ADDR_HEX, 32'h1234_ABCD, n);
    expect_out(32'h1234_ABCD, ADDR_HEX, n + 2);
    wait_idle(50);

    // Dec 12345678 with busy window n+1..n+34
    bus_write(1'b1, ADDR_DEC, 32'h00BC_614E, n);
    expect_out(32'h1234_5678, ADDR_DEC, n + 34);
    sample_neg(b); check("busy_n1", 64'(b), 64'(1));
    step(n + 17 - cyc); sample_neg(b); check("busy_n17", 64'(b), 64'(1));
    step(n + 34 - cyc); sample_neg(b); check("busy_n34", 64'(b), 64'(1));
    sample_neg(b); check("busy_n35", 64'(b), 64'(0));
    wait_idle(50);

    // Range boundaries
    bus_write(1'b1, ADDR_DEC, 32'd99_999_999, n);
    expect_out(32'h9999_9999, ADDR_DEC, n + 34);
    wait_idle(60);
    bus_write(1'b1, ADDR_DEC, 32'd100_000_000, n);
    expect_out(32'hEEEE_EEEE, ADDR_DEC, n + 2);
    wait_idle(60);
    bus_write(1'b1, ADDR_DEC, 32'd0, n);
    expect_out(32'h0, ADDR_DEC, n + 34);
    wait_idle(60);

    // Overwrite of a pending entry during a conversion
    bus_write(1'b1, ADDR_DEC, 32'd10, n);
    expect_out(32'h10, ADDR_DEC, n + 34);
    step(1);
    bus_write(1'b1, ADDR_DEC, 32'd5, n2);
    bus_write(1'b1, ADDR_DEC, 32'd7, n2);
    expect_out(32'h7, ADDR_DEC, n + 68);
    step(1);
    check("drop_cnt_1", 64'(bus_if.drop_cnt), 64'(1));
    wait_idle(100);

    // Non-accepted cycles
    bus_write(1'b0, ADDR_DEC, 32'd42, n);
    bus_write(1'b1, ADDR_DEC + 32'd8, 32'd42, n);
    sample_neg(b); check("busy_ignored", 64'(b), 64'(0));
    step(40);
    check("busy_ignored_late", 64'(bus_if.busy), 64'(0));

    // Reset mid-conversion
    bus_write(1'b1, ADDR_DEC, 32'd31337, n);
    step(n + 10 - cyc);
    rst = 1'b1;
    exp_q.delete(); exp_addr_q.delete(); exp_cyc_q.delete();
    #1;
    check("mid_rst_cal_result", 64'(bus_if.cal_result), 64'(0));
    check("mid_rst_addr", 64'(bus_if.addr_digtube), 64'(0));
    check("mid_rst_busy", 64'(bus_if.busy), 64'(0));
    check("mid_rst_drop", 64'(bus_if.drop_cnt), 64'(0));
    check("mid_rst_ena", 64'(bus_if.digtube_ena), 64'(0));
    step(2);
    rst = 1'b0;
    step(40);
    bus_write(1'b1, ADDR_HEX, 32'hCAFE_F00D, n);
    expect_out(32'hCAFE_F00D, ADDR_HEX, n + 2);
    wait_idle(50);

    // Randomized writes from idle
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin dec = 1'b0; d = $urandom; end
        1: begin dec = 1'b1; d = $urandom_range(0, 99_999_999); end
        2: begin dec = 1'b1; d = $urandom_range(100_000_000, 32'hFFFF_FFFF); end
        default: begin dec = 1'b1; d = $urandom_range(0, 9999); end
      endcase
      a = dec ? ADDR_DEC : ADDR_HEX;
      bus_write(1'b1, a, d, n);
      expect_out(ref_result(dec, d), a,
                 n + ((dec && d <= 32'd99_999_999) ? 34 : 2));
      wait_idle(60);
      step($urandom_range(0, 3));
    end

    step(5);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("drop_cnt_final", 64'(bus_if.drop_cnt), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
